piso_serializer: RTL



---
 rtl/piso_serializer.sv | 112 +++++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// MSB-first parallel-in/serial-out transmitter with a one-word holding buffer.
// Optional trailing even-parity bit when PISO_PARITY_EN is defined.
module piso_serializer #(
    parameter int N  = 16,
    parameter int CW = $clog2(N)
) (
    input  logic         Clk,
    input  logic         reset,
    input  logic [N-1:0] D_In,
    input  logic         Load_Valid,
    output logic         Load_Ready,
    output logic         S_Out,
    output logic         Frame,
    output logic         Busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

    state_t         state;
    logic [N-1:0]   hold_buf;
    logic [N-1:0]   shift_reg;
    logic           buf_full;
    logic [CW-1:0]  cnt;
    logic           last;
    logic           reload;
`ifdef PISO_PARITY_EN
    logic           parity_q;
`endif

    assign last       = (cnt == CW'(N - 1));
    assign Load_Ready = ~buf_full;
    assign Busy       = (state != IDLE) | buf_full;

    // Reload happens on the edge that retires the final bit of the frame,
    // so a buffered word follows with no idle cycle on the line.
    always_comb begin
        reload = 1'b0;
        case (state)
            IDLE:    reload = buf_full;
`ifdef PISO_PARITY_EN
            SHIFT:   reload = 1'b0;
            PARITY:  reload = buf_full;
`else
            SHIFT:   reload = last & buf_full;
            PARITY:  reload = 1'b0;
`endif
            default: reload = 1'b0;
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            hold_buf  <= '0;
            shift_reg <= '0;
            buf_full  <= 1'b0;
            cnt       <= '0;
            S_Out     <= 1'b0;
            Frame     <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            // Accept and reload are mutually exclusive: accept needs an empty buffer.
            if (Load_Valid && !buf_full) begin
                hold_buf <= D_In;
                buf_full <= 1'b1;
            end
            if (reload) begin
                shift_reg <= hold_buf;
                buf_full  <= 1'b0;
                S_Out     <= hold_buf[N-1];
                Frame     <= 1'b1;
                cnt       <= '0;
                state     <= SHIFT;
`ifdef PISO_PARITY_EN
                parity_q  <= ^hold_buf;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        S_Out <= 1'b0;
                        Frame <= 1'b0;
                    end
                    SHIFT: begin
                        if (!last) begin
                            cnt       <= cnt + 1'b1;
                            shift_reg <= {shift_reg[N-2:0], 1'b0};
                            S_Out     <= shift_reg[N-2];
                        end else begin
`ifdef PISO_PARITY_EN
                            state <= PARITY;
                            S_Out <= parity_q;
`else
                            state <= IDLE;
                            S_Out <= 1'b0;
                            Frame <= 1'b0;
`endif
                        end
                    end
                    PARITY: begin
                        state <= IDLE;
                        S_Out <= 1'b0;
                        Frame <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
